// File: rtl/decoder_pkg.sv
// Shared widths and the one-hot helper for the registered 3-to-8 decoder.
// Imported by the interface, the combinational core and the top level.
package decoder_pkg;

    localparam int SEL_W     = 3;
    localparam int NUM_LINES = 8;

    function automatic logic [NUM_LINES-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [NUM_LINES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_3x8_if.sv
// Select/enable inputs and decoded-line outputs of decoder_3x8, bundled with
// a master (driver) and slave (decoder) view.
interface decoder_3x8_if;
    import decoder_pkg::*;

    logic en;
    logic A2;
    logic A1;
    logic A0;
    logic Y0;
    logic Y1;
    logic Y2;
    logic Y3;
    logic Y4;
    logic Y5;
    logic Y6;
    logic Y7;
    logic valid;
    logic changed;

    modport master (
        output en, A2, A1, A0,
        input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, valid, changed
    );

    modport slave (
        input  en, A2, A1, A0,
        output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, valid, changed
    );

endinterface

// File: rtl/decoder_3x8_core.sv
// Purely combinational 3-bit select to 8-line one-hot decode with enable.
// Produces active-high lines; polarity is handled by the top level.
module decoder_3x8_core
    import decoder_pkg::*;
(
    input  logic                 i_en,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [NUM_LINES-1:0] o_lines
);

    assign o_lines = i_en ? onehot8(i_sel) : '0;

endmodule

// File: rtl/decoder_3x8.sv
// Registered 3-to-8 decoder: one-hot lines, valid and a selection-change
// pulse, all straight from flops so the outputs are glitch-free.
module decoder_3x8
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_3x8_if.slave   bus
);

    localparam logic [NUM_LINES-1:0] POL_MASK = {NUM_LINES{OUT_ACTIVE_LOW}};

    logic [SEL_W-1:0]     w_sel;
    logic [NUM_LINES-1:0] w_lines;
    logic [NUM_LINES-1:0] w_lines_mux;
    logic [SEL_W:0]       w_sel_state;

    logic [NUM_LINES-1:0] r_y;
    logic                 r_valid;
    logic                 r_changed;
    logic [SEL_W:0]       r_prev_state;

    assign w_sel = {bus.A2, bus.A1, bus.A0};

    decoder_3x8_core u_core (
        .i_en    (bus.en),
        .i_sel   (w_sel),
        .o_lines (w_lines)
    );

    // Reset selects "no line" before the polarity mask, so reset lands on the inactive level.
    assign w_lines_mux = rst_n ? w_lines : '0;

    // Select bits only count while enabled; a disabled decoder has one state regardless of A2..A0.
    assign w_sel_state = bus.en ? {1'b1, w_sel} : '0;

    always_ff @(posedge clk) begin
        r_y <= w_lines_mux ^ POL_MASK;
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_changed    <= 1'b0;
            r_prev_state <= '0;
        end else begin
            r_valid      <= bus.en;
            r_changed    <= (w_sel_state != r_prev_state);
            r_prev_state <= w_sel_state;
        end
    end

    assign bus.Y0      = r_y[0];
    assign bus.Y1      = r_y[1];
    assign bus.Y2      = r_y[2];
    assign bus.Y3      = r_y[3];
    assign bus.Y4      = r_y[4];
    assign bus.Y5      = r_y[5];
    assign bus.Y6      = r_y[6];
    assign bus.Y7      = r_y[7];
    assign bus.valid   = r_valid;
    assign bus.changed = r_changed;

endmodule

// File: tb/tb_decoder_3x8.sv
// Scoreboard bench for decoder_3x8: directed vectors push expected responses,
// a monitor pops and compares both polarity builds every cycle.
module tb_decoder_3x8;

    typedef struct {
        logic [7:0] y;
        logic       v;
        logic       c;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t exp_q[$];
    int   n_vectors;
    int   n_miscompares;
    bit   stim_done;

    decoder_3x8_if if_h ();
    decoder_3x8_if if_l ();

    decoder_3x8 #(.OUT_ACTIVE_LOW(1'b0)) dut_h (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_h.slave)
    );

    decoder_3x8 #(.OUT_ACTIVE_LOW(1'b1)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lines_h();
        return {if_h.Y7, if_h.Y6, if_h.Y5, if_h.Y4, if_h.Y3, if_h.Y2, if_h.Y1, if_h.Y0};
    endfunction

    function automatic logic [7:0] lines_l();
        return {if_l.Y7, if_l.Y6, if_l.Y5, if_l.Y4, if_l.Y3, if_l.Y2, if_l.Y1, if_l.Y0};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        if (act !== req) begin
            n_miscompares++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, n_vectors, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        if (act !== req) begin
            n_miscompares++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, n_vectors, act, req);
        end
    endtask

    // Drive one vector ahead of the next rising edge; y is the active-high expectation.
    task automatic apply(input logic rst, input logic en, input logic [2:0] sel,
                         input logic [7:0] y, input logic v, input logic c);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        if_h.en = en;
        {if_h.A2, if_h.A1, if_h.A0} = sel;
        if_l.en = en;
        {if_l.A2, if_l.A1, if_l.A0} = sel;
        e.y = y;
        e.v = v;
        e.c = c;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vectors++;
                check8("y_high",       lines_h(),    e.y);
                check1("valid_high",   if_h.valid,   e.v);
                check1("changed_high", if_h.changed, e.c);
                check8("y_low",        lines_l(),    ~e.y);
                check1("valid_low",    if_l.valid,   e.v);
                check1("changed_low",  if_l.changed, e.c);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] sweep_y [8];
        sweep_y = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        n_vectors     = 0;
        n_miscompares = 0;
        stim_done     = 1'b0;
        rst_n   = 1'b0;
        if_h.en = 1'b0; {if_h.A2, if_h.A1, if_h.A0} = 3'b000;
        if_l.en = 1'b0; {if_l.A2, if_l.A1, if_l.A0} = 3'b000;

        // reset dominates en=1 with select 101
        apply(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);

        // full sweep, every step is a new selection
        for (int i = 0; i < 8; i++)
            apply(1'b1, 1'b1, 3'(i), sweep_y[i], 1'b1, 1'b1);

        // hold 011
        apply(1'b1, 1'b1, 3'b011, 8'h08, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 3'b011, 8'h08, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 3'b011, 8'h08, 1'b1, 1'b0);

        // enable drop on 110
        apply(1'b1, 1'b1, 3'b110, 8'h40, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 3'b110, 8'h00, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 3'b110, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 3'b110, 8'h40, 1'b1, 1'b1);

        // reset mid-operation while decoding 111
        apply(1'b1, 1'b1, 3'b111, 8'h80, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 3'b111, 8'h80, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 3'b111, 8'h80, 1'b1, 1'b1);

        // wrap 7 -> 0, then 010 (active-low build expects only Y2 low)
        apply(1'b1, 1'b1, 3'b000, 8'h01, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 3'b010, 8'h04, 1'b1, 1'b1);
        apply(1'b1, 1'b1, 3'b010, 8'h04, 1'b1, 1'b0);

        // reset with en=0, then first decode after reset
        apply(1'b0, 1'b0, 3'b100, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 3'b100, 8'h10, 1'b1, 1'b1);

        stim_done = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
